ifmap_stream_tx: RTL and testbench

IFMAP_STREAM_TX -- requirements
Module: ifmap_stream_tx

---
 rtl/ifmap_stream_tx.sv | 154 +++++++++++++++
 tb/tb_ifmap_stream_tx.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ifmap_stream_tx.sv
// Streams an img_w x img_h frame from a 1-cycle-latency memory into a ready/valid pixel port.
// Define IFMAP_PAD_EN to wrap the frame in a one-pixel zero border.
module ifmap_stream_tx #(
  parameter int DW = 16,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    img_w,
  input  logic [7:0]    img_h,
  input  logic [AW-1:0] base_addr,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_eol,
  output logic          pix_last,
  output logic          busy,
  output logic          done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

`ifdef IFMAP_PAD_EN
  localparam logic [8:0] PAD = 9'd2;
`else
  localparam logic [8:0] PAD = 9'd0;
`endif

  logic [1:0]    state;
  logic [8:0]    fw, fh, col, row;
  logic [AW-1:0] rd_addr;

  // Issue slot in flight: memory data (or a border zero) lands next cycle.
  logic          pend_vld, pend_pad, pend_eol, pend_last;

  logic [DW-1:0] fifo_data [2];
  logic [1:0]    fifo_eol, fifo_last;
  logic          head, tail;
  logic [1:0]    cnt;

  logic [1:0]    occ;
  logic          issue, at_eol, at_last, border, xfer, push, pop;
  logic [DW-1:0] pend_data;

  always_comb begin
    occ       = cnt + {1'b0, pend_vld};
    issue     = !rst && (state == RUN) && (occ < 2'd2);
    at_eol    = (col == fw - 9'd1);
    at_last   = at_eol && (row == fh - 9'd1);
`ifdef IFMAP_PAD_EN
    border    = (col == 9'd0) || at_eol || (row == 9'd0) || (row == fh - 9'd1);
`else
    border    = 1'b0;
`endif
    pend_data = pend_pad ? '0 : mem_rdata;
  end

  // Empty FIFO bypasses the returning read so the first pixel appears one cycle after its read.
  always_comb begin
    pix_valid = 1'b0;
    pix_data  = '0;
    pix_eol   = 1'b0;
    pix_last  = 1'b0;
    if (!rst) begin
      if (cnt != 2'd0) begin
        pix_valid = 1'b1;
        pix_data  = fifo_data[head];
        pix_eol   = fifo_eol[head];
        pix_last  = fifo_last[head];
      end else if (pend_vld) begin
        pix_valid = 1'b1;
        pix_data  = pend_data;
        pix_eol   = pend_eol;
        pix_last  = pend_last;
      end
    end
    xfer = pix_valid && pix_ready;
    pop  = xfer && (cnt != 2'd0);
    push = pend_vld && !(xfer && (cnt == 2'd0));
  end

  assign mem_rd_en = issue && !border;
  assign mem_addr  = rst ? '0 : rd_addr;
  assign busy      = !rst && (state != IDLE);
  assign done      = !rst && (state == FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fw        <= '0;
      fh        <= '0;
      col       <= '0;
      row       <= '0;
      rd_addr   <= '0;
      pend_vld  <= 1'b0;
      pend_pad  <= 1'b0;
      pend_eol  <= 1'b0;
      pend_last <= 1'b0;
      fifo_eol  <= '0;
      fifo_last <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          fw      <= {1'b0, img_w} + PAD;
          fh      <= {1'b0, img_h} + PAD;
          col     <= '0;
          row     <= '0;
          rd_addr <= base_addr;
          state   <= (img_w == 8'd0 || img_h == 8'd0) ? FIN : RUN;
        end
        RUN: if (issue) begin
          if (at_eol) begin
            col <= '0;
            row <= row + 9'd1;
          end else begin
            col <= col + 9'd1;
          end
          // Interior pixels are contiguous in memory, so the address just counts reads.
          if (!border) rd_addr <= rd_addr + 1'b1;
          if (at_last) state <= DRAIN;
        end
        DRAIN: if (xfer && pix_last) state <= FIN;
        default: state <= IDLE;
      endcase

      pend_vld <= issue;
      if (issue) begin
        pend_pad  <= border;
        pend_eol  <= at_eol;
        pend_last <= at_last;
      end

      if (push) begin
        fifo_data[tail] <= pend_data;
        fifo_eol[tail]  <= pend_eol;
        fifo_last[tail] <= pend_last;
        tail            <= ~tail;
      end
      if (pop) head <= ~head;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifmap_stream_tx.sv
// Bench for ifmap_stream_tx: directed frames plus random frames against a raster-order reference model.
module tb_ifmap_stream_tx;
  localparam int DW = 16;
  localparam int AW = 12;
`ifdef IFMAP_PAD_EN
  localparam int PADN = 1;
`else
  localparam int PADN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, pix_ready;
  logic [7:0]    img_w, img_h;
  logic [AW-1:0] base_addr, mem_addr;
  logic          mem_rd_en, pix_valid, pix_eol, pix_last, busy, done;
  logic [DW-1:0] mem_rdata, pix_data;
  logic [DW-1:0] mem [1<<AW];

  int n_cmp = 0;
  int n_err = 0;

  ifmap_stream_tx #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .img_w(img_w), .img_h(img_h),
    .base_addr(base_addr), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_eol(pix_eol), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory with exactly one cycle of read latency.
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({mem_rd_en, pix_valid, pix_eol, pix_last, busy, done}), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_data"}, 32'(pix_data), 32'd0);
  endtask

  // mode: 0 ready held 1, 1 ready toggles 1010..., 2 random ready.
  // rst_after >= 0 resets the block after that many transfers and abandons the frame.
  task automatic run_frame(input int w, input int h, input int base, input int mode, input int rst_after);
    int xd[$], xe[$], xl[$], xa[$];
    int fw, fh, npix, nxfer, last_k, first_rd;
    bit prev_stall, done_seen;
    logic [31:0] prev;
    logic [AW-1:0] a;

    fw = w + 2*PADN;
    fh = h + 2*PADN;
    first_rd = 0;
    if (w != 0 && h != 0) begin
      for (int r = 0; r < fh; r++)
        for (int c = 0; c < fw; c++) begin
          bit inner;
          inner = (r >= PADN) && (r < h + PADN) && (c >= PADN) && (c < w + PADN);
          a = AW'(base + (r - PADN) * w + (c - PADN));
          if (r == 0 && c == 0) first_rd = inner ? 1 : 0;
          xd.push_back(inner ? int'(mem[a]) : 0);
          if (inner) xa.push_back(int'(a));
          xe.push_back(c == fw - 1 ? 1 : 0);
          xl.push_back((r == fh - 1 && c == fw - 1) ? 1 : 0);
        end
    end
    npix = xd.size();
    nxfer = 0; last_k = -1; prev_stall = 0; done_seen = 0; prev = '0;

    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; img_w = 8'(w); img_h = 8'(h); base_addr = AW'(base); pix_ready = 1'b0;

    for (int k = 1; k < 600 && !done_seen; k++) begin
      @(negedge clk);
      if (rst_after >= 0 && nxfer == rst_after) begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("rst_after");
        return;
      end
      // Start while busy and input churn after acceptance must not disturb the frame.
      start     = (k == 5);
      img_w     = 8'($urandom);
      img_h     = 8'($urandom);
      base_addr = AW'($urandom);
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (k % 2 == 0);
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase

      if (k == 1) chk("busy_on", 32'(busy), 32'd1);
      if (k == 1 && npix > 0) chk("first_rd", 32'(mem_rd_en), 32'(first_rd));
      if (k < 2) chk("early_valid", 32'(pix_valid), 32'd0);
      if (k == 2 && npix > 0) chk("first_valid", 32'(pix_valid), 32'd1);

      if (mem_rd_en) begin
        if (xa.size() == 0) chk("extra_rd", 32'd1, 32'd0);
        else chk("rd_addr", 32'(mem_addr), 32'(xa.pop_front()));
      end

      if (prev_stall) begin
        chk("stall_valid", 32'(pix_valid), 32'd1);
        chk("stall_hold", 32'({pix_data, pix_eol, pix_last}), prev);
      end

      if (pix_valid && pix_ready) begin
        if (xd.size() == 0) chk("extra_pix", 32'd1, 32'd0);
        else begin
          chk("pix_data", 32'(pix_data), 32'(xd.pop_front()));
          chk("pix_eol", 32'(pix_eol), 32'(xe.pop_front()));
          chk("pix_last", 32'(pix_last), 32'(xl.pop_front()));
        end
        if (mode == 0) chk("b2b_cycle", 32'(k), 32'(2 + nxfer));
        nxfer++;
        last_k = k;
      end
      prev_stall = pix_valid && !pix_ready;
      prev = 32'({pix_data, pix_eol, pix_last});

      if (done) begin
        done_seen = 1;
        chk("done_all_pix", 32'(xd.size()), 32'd0);
        chk("done_all_rd", 32'(xa.size()), 32'd0);
        chk("done_cycle", 32'(k), 32'(npix > 0 ? last_k + 1 : 1));
        chk("fin_busy", 32'(busy), 32'd1);
        start = 1'b1;  // lands in the FIN cycle and must be ignored
      end
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);

    @(negedge clk);
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_off", 32'(busy), 32'd0);
    chk("valid_off", 32'(pix_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    img_w = '0; img_h = '0; base_addr = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    run_frame(3, 3, 'h010, 0, -1);
    run_frame(4, 2, 'h020, 1, -1);
    run_frame(0, 3, 'h000, 0, -1);
    run_frame(3, 0, 'h000, 0, -1);
    run_frame(2, 2, 'hFFE, 0, -1);
    run_frame(4, 4, 'h040, 0, 3);
    run_frame(4, 4, 'h080, 0, -1);
    run_frame(2, 2, 'h010, 0, -1);
    run_frame(1, 1, 'h123, 1, -1);

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    for (int n = 0; n < 8; n++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(0, (1 << AW) - 1),
                (n % 3 == 0) ? 0 : 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
